// File: rtl/equiv_sweep_ctrl.sv
// ============================================================================
// Module   : equiv_sweep_ctrl
// Purpose  : Exhaustive equivalence sweep of two N_IN-input boolean functions.
//            Optional macro STOP_ON_FAIL_EN ends the sweep at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module equiv_sweep_ctrl #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] vec_out,
   input  logic            y_a,
   input  logic            y_b,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   mismatch_cnt,
   output logic [N_IN-1:0] first_fail,
   output logic            first_fail_vld
);

   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CW-1:0]   C_SETTLE   = CW'(SETTLE);
   localparam logic [CW-1:0]   C_CNT_ONE  = CW'(1);
   localparam logic [N_IN-1:0] C_VEC_LAST = '1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   settle_q, settle_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN:0]   cnt_q, cnt_d;
   logic [N_IN-1:0] ff_q, ff_d;
   logic            ffv_q, ffv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   logic            w_miss;
   logic [N_IN:0]   w_cnt_inc;

   assign w_miss    = y_a ^ y_b;
   assign w_cnt_inc = cnt_q + {{N_IN{1'b0}}, w_miss};

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      vec_d    = vec_q;
      cnt_d    = cnt_q;
      ff_d     = ff_q;
      ffv_d    = ffv_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               vec_d    = '0;
               cnt_d    = '0;
               ff_d     = '0;
               ffv_d    = 1'b0;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               busy_d   = 1'b1;
               settle_d = C_SETTLE;
               state_d  = S_WAIT;
            end
         end

         S_WAIT: begin
            settle_d = settle_q - C_CNT_ONE;
            if (settle_q == C_CNT_ONE) begin
               state_d = S_SAMPLE;
            end
         end

         S_SAMPLE: begin
            cnt_d = w_cnt_inc;
            if (w_miss && !ffv_q) begin
               ff_d  = vec_q;
               ffv_d = 1'b1;
            end
`ifdef STOP_ON_FAIL_EN
            if (w_miss) begin
               // vec_out is left on the failing vector for inspection
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
            end else if (vec_q == C_VEC_LAST) begin
`else
            if (vec_q == C_VEC_LAST) begin
`endif
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (w_cnt_inc == '0);
            end else begin
               vec_d    = vec_q + 1'b1;
               settle_d = C_SETTLE;
               state_d  = S_WAIT;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         vec_q    <= '0;
         cnt_q    <= '0;
         ff_q     <= '0;
         ffv_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         vec_q    <= vec_d;
         cnt_q    <= cnt_d;
         ff_q     <= ff_d;
         ffv_q    <= ffv_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign vec_out        = vec_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign mismatch_cnt   = cnt_q;
   assign first_fail     = ff_q;
   assign first_fail_vld = ffv_q;

endmodule

`default_nettype wire

// File: tb/tb_equiv_sweep_ctrl.sv
// ============================================================================
// Module   : tb_equiv_sweep_ctrl
// Purpose  : Randomised self-checking bench for equiv_sweep_ctrl against a
//            truth-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_equiv_sweep_ctrl;

   localparam int N  = 3;
   localparam int S  = 1;
   localparam int NV = 1 << N;
   localparam int LIMIT = 4 * NV * (S + 1) + 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [N-1:0]  vec_out;
   logic          y_a, y_b;
   logic          busy, done, pass;
   logic [N:0]    mismatch_cnt;
   logic [N-1:0]  first_fail;
   logic          first_fail_vld;

   logic [NV-1:0] fa, fb;

   int n_cmp = 0;
   int n_err = 0;

   equiv_sweep_ctrl #(.N_IN(N), .SETTLE(S)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .vec_out        (vec_out),
      .y_a            (y_a),
      .y_b            (y_b),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .mismatch_cnt   (mismatch_cnt),
      .first_fail     (first_fail),
      .first_fail_vld (first_fail_vld)
   );

   always #5 clk = ~clk;

   // The two "implementations" are truth tables indexed by the driven vector.
   assign y_a = fa[vec_out];
   assign y_b = fb[vec_out];

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".vec"},  int'(vec_out), 0);
      chk({tag, ".busy"}, int'(busy), 0);
      chk({tag, ".done"}, int'(done), 0);
      chk({tag, ".pass"}, int'(pass), 0);
      chk({tag, ".cnt"},  int'(mismatch_cnt), 0);
      chk({tag, ".ff"},   int'(first_fail), 0);
      chk({tag, ".ffv"},  int'(first_fail_vld), 0);
   endtask

   // One sweep; glitch_at > 0 pulses start on that edge number of the sweep.
   task automatic sweep(input string tag, input logic [NV-1:0] a,
                        input logic [NV-1:0] b, input int glitch_at);
      logic [NV-1:0] diff;
      int exp_cnt, exp_ff, exp_vld, exp_lat, exp_vec, k;
      diff    = a ^ b;
      exp_cnt = 0;
      exp_ff  = 0;
      exp_vld = 0;
      for (int i = 0; i < NV; i++) begin
         if (diff[i]) begin
            if (exp_vld == 0) exp_ff = i;
            exp_vld = 1;
            exp_cnt++;
         end
      end
      exp_lat = NV * (S + 1);
      exp_vec = NV - 1;
`ifdef STOP_ON_FAIL_EN
      if (exp_vld != 0) begin
         exp_cnt = 1;
         exp_lat = (exp_ff + 1) * (S + 1);
         exp_vec = exp_ff;
      end
`endif
      fa    = a;
      fb    = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, ".go_busy"}, int'(busy), 1);
      chk({tag, ".go_done"}, int'(done), 0);
      chk({tag, ".go_vec"},  int'(vec_out), 0);
      chk({tag, ".go_cnt"},  int'(mismatch_cnt), 0);
      chk({tag, ".go_ffv"},  int'(first_fail_vld), 0);
      chk({tag, ".go_pass"}, int'(pass), 0);
      if (glitch_at == 1 && exp_lat > 1) start = 1'b1;
      for (k = 1; k <= LIMIT; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) break;
         chk({tag, ".run_vec"},  int'(vec_out), k / (S + 1));
         chk({tag, ".run_busy"}, int'(busy), 1);
         if (k + 1 == glitch_at && glitch_at < exp_lat) start = 1'b1;
      end
      chk({tag, ".latency"}, k, exp_lat);
      chk({tag, ".busy"},    int'(busy), 0);
      chk({tag, ".pass"},    int'(pass), (exp_cnt == 0) ? 1 : 0);
      chk({tag, ".cnt"},     int'(mismatch_cnt), exp_cnt);
      chk({tag, ".ffv"},     int'(first_fail_vld), exp_vld);
      chk({tag, ".ff"},      int'(first_fail), exp_ff);
      chk({tag, ".vec"},     int'(vec_out), exp_vec);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, ".hold_done"}, int'(done), 1);
      chk({tag, ".hold_cnt"},  int'(mismatch_cnt), exp_cnt);
      chk({tag, ".hold_vec"},  int'(vec_out), exp_vec);
   endtask

   initial begin
      logic [NV-1:0] r, flip;
      rst_n = 1'b0;
      start = 1'b0;
      fa    = '0;
      fb    = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      r = NV'($urandom);
      sweep("equiv", r, r, 0);
      flip = '0;
      flip[5] = 1'b1;
      sweep("flip5", r, r ^ flip, 0);
      sweep("invert", r, ~r, 0);
      sweep("glitch6", r, r ^ flip, 6);
      sweep("restart_eq", r, r, 0);

      // Reset mid-sweep, with start asserted at the same edge
      fa = r;
      fb = ~r;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = 1'b1;
      check_reset_vals("midrst");
      @(posedge clk);
      #1;
      chk("midrst.idle_busy", int'(busy), 0);
      sweep("after_rst", r, r, 0);

      for (int it = 0; it < 20; it++) begin
         int mode, g;
         r    = NV'($urandom);
         mode = int'($urandom_range(0, 3));
         flip = '0;
         case (mode)
            0: flip = '0;
            1: flip[$urandom_range(0, NV - 1)] = 1'b1;
            2: flip = '1;
            default: flip = NV'($urandom);
         endcase
         g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NV * (S + 1) - 1)) : 0;
         sweep("rand", r, r ^ flip, g);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/equiv_sweep_ctrl.md
Name: equiv_sweep_ctrl

Overview:
- Sequencer for exhaustive equivalence checking of two combinational implementations (A, B) of the same N-input boolean function.
- Drives every input vector 0..2^N-1 onto both implementations, waits a settle time, and compares their outputs.
- Counts mismatches, records the first failing vector, and reports pass/fail through a start/busy/done handshake.
- Sits beside the boolean-function modules as the self-checking sweep engine, in place of a hand-written testbench loop.

Parameters:
- N_IN, 3, number of function inputs; sweep covers 2^N_IN vectors (legal 1..16).
- SETTLE, 1, clock cycles vec_out is held before outputs are sampled (legal >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin sweep; honoured only in IDLE or DONE.
- vec_out  output  N_IN  vector driven to both implementations (bit N_IN-1 = a, ..., bit 0 = c).
- y_a  input  1  output of implementation A.
- y_b  input  1  output of implementation B.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  high while in DONE; held until the next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff mismatch_cnt==0.
- mismatch_cnt  output  N_IN+1  mismatching vectors seen; width holds 2^N_IN without wrap.
- first_fail  output  N_IN  first mismatching vector; valid when first_fail_vld=1.
- first_fail_vld  output  1  set on the first mismatch of a sweep.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; vec_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, first_fail_vld=0, settle counter=0. Reset overrides everything, including mid-sweep.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE/DONE, start=1: vec_out<=0, mismatch_cnt<=0, first_fail<=0, first_fail_vld<=0, done<=0, pass<=0, busy<=1, settle counter<=SETTLE, state<=WAIT.
- WAIT: counter decrements each cycle. When counter==1, state<=SAMPLE. WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE: compare y_a against y_b for the current vec_out.
  - On mismatch: mismatch_cnt += 1. If first_fail_vld==0, first_fail<=vec_out and first_fail_vld<=1.
  - If vec_out == all-ones: state<=DONE, busy<=0, done<=1; pass<=1 iff the final count (including this sample) is 0.
  - Else: vec_out<=vec_out+1, counter<=SETTLE, state<=WAIT.
- Termination is by all-ones compare, never by counter overflow. vec_out never wraps during a sweep.
- Latency: start accepted at edge 0 gives done=1 after exactly 2^N_IN*(SETTLE+1) further edges. With defaults, that is 16 cycles.
- start is ignored while busy=1 (WAIT, SAMPLE).
- In DONE: vec_out holds its last value; all result outputs are stable.
- Simultaneous start and rst_n=0: reset wins.
- mismatch_cnt saturation is not needed; the width covers the maximum count.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- Defined: a mismatch in SAMPLE sends the block directly to DONE (busy<=0, done<=1, pass<=0, mismatch_cnt=1, first_fail=vec_out, first_fail_vld=1). vec_out holds the failing vector.
- Undefined: the sweep always covers all 2^N_IN vectors and counts every mismatch.

Test Plan:
- Equivalent pair (y_a=y_b for all vectors), defaults, start pulse -> done=1 exactly 16 cycles later, pass=1, mismatch_cnt=0, first_fail_vld=0, vec_out=7.
- y_b inverted only at vector 5 -> done after 16 cycles, pass=0, mismatch_cnt=1, first_fail=5, first_fail_vld=1.
- y_b = ~y_a for every vector -> mismatch_cnt=8 (4'b1000, no wrap), first_fail=0, pass=0.
- start pulsed again at cycle 6 of a sweep -> ignored; done still at cycle 16 with unchanged results. Start in DONE -> results clear and a new sweep begins.
- rst_n=0 at cycle 9 of a sweep -> next cycle all outputs at reset values, state IDLE; a later start gives a full 16-cycle sweep.
- STOP_ON_FAIL_EN defined, mismatch at vector 3, SETTLE=2 -> done after 4*3=12 cycles, vec_out=3, mismatch_cnt=1, pass=0.
